// File: rtl/avalon_mem_responder.sv
// Avalon-MM pipelined slave over a word-addressed on-chip memory, with a fixed
// response latency and optional periodic waitrequest stalls that mimic refresh.
module avalon_mem_responder #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LAT     = 2,
    parameter int unsigned STALL_PERIOD = 0,
    parameter int unsigned STALL_LEN    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [DATA_W-1:0] slave_writedata,
    input  logic [3:0]        slave_byteenable,
    output logic              slave_waitrequest,
    output logic [DATA_W-1:0] slave_readdata,
    output logic              slave_readdatavalid,
    output logic              slave_writeresponsevalid,
    output logic [1:0]        slave_response
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CYC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam int unsigned STL_W = (STALL_LEN > 1) ? $clog2(STALL_LEN) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
    localparam logic [STL_W-1:0] STL_LAST  = STL_W'(STALL_LEN - 1);
    localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        READY,
        STALL
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              is_read;
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
    } rsp_t;

    state_t            state, state_nxt;
    logic [CYC_W-1:0]  cyc_cnt, cyc_nxt;
    logic [STL_W-1:0]  stl_cnt, stl_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    rsp_t              pipe [READ_LAT];
    rsp_t              entry;
    rsp_t              head;
    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    // Stall generator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= READY;
            cyc_cnt <= '0;
            stl_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_nxt;
            stl_cnt <= stl_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt;
        stl_nxt   = stl_cnt;
        case (state)
            READY: begin
                if (STALL_PERIOD != 0) begin
                    if (cyc_cnt == CYC_LAST) begin
                        state_nxt = STALL;
                        cyc_nxt   = '0;
                    end else begin
                        cyc_nxt = cyc_cnt + 1'b1;
                    end
                end
            end
            STALL: begin
                if (stl_cnt == STL_LAST) begin
                    state_nxt = READY;
                    stl_nxt   = '0;
                end else begin
                    stl_nxt = stl_cnt + 1'b1;
                end
            end
        endcase
    end

    assign slave_waitrequest = rst | (state == STALL);

    // Command decode
    assign accept   = (slave_read | slave_write) & ~slave_waitrequest;
    assign in_range = {1'b0, slave_address} < DEPTH_LIM;
    assign idx      = slave_address[IDX_W-1:0];
    assign rd_word  = in_range ? mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (accept && slave_write && in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (slave_byteenable[b]) begin
                    mem[idx][8*b +: 8] <= slave_writedata[8*b +: 8];
                end
            end
        end
    end

    // Write wins over a simultaneous read, so is_read keys off slave_write alone
    always_comb begin
        entry = '0;
        if (accept) begin
            entry.valid   = 1'b1;
            entry.is_read = ~slave_write;
            entry.resp    = in_range ? RESP_OKAY : RESP_DECERR;
            entry.data    = slave_write ? '0 : rd_word;
        end
    end

    // Response pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= entry;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign head                     = pipe[READ_LAT-1];
    assign slave_readdatavalid      = head.valid & head.is_read;
    assign slave_writeresponsevalid = head.valid & ~head.is_read;
    assign slave_response           = head.resp;
    assign slave_readdata           = head.data;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench for avalon_mem_responder: per-cycle vector table on a
// non-stalling instance, plus reset-flush and injected-stall sequences.
module tb_avalon_mem_responder;

    logic        clk = 1'b0;
    logic        rst, rd, wr;
    logic [18:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wreq, rvalid, wvalid;
    logic [31:0] rdata;
    logic [1:0]  resp;

    logic        rst_s, rd_s, wr_s;
    logic [18:0] addr_s;
    logic [31:0] wdata_s;
    logic [3:0]  be_s;
    logic        wreq_s, rvalid_s, wvalid_s;
    logic [31:0] rdata_s;
    logic [1:0]  resp_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    avalon_mem_responder #(
        .DATA_W(32), .ADDR_W(19), .DEPTH(1024), .READ_LAT(2),
        .STALL_PERIOD(0), .STALL_LEN(3)
    ) dut (
        .clk(clk), .rst(rst),
        .slave_address(addr), .slave_read(rd), .slave_write(wr),
        .slave_writedata(wdata), .slave_byteenable(be),
        .slave_waitrequest(wreq), .slave_readdata(rdata),
        .slave_readdatavalid(rvalid), .slave_writeresponsevalid(wvalid),
        .slave_response(resp)
    );

    avalon_mem_responder #(
        .DATA_W(32), .ADDR_W(19), .DEPTH(1024), .READ_LAT(2),
        .STALL_PERIOD(16), .STALL_LEN(3)
    ) dut_s (
        .clk(clk), .rst(rst_s),
        .slave_address(addr_s), .slave_read(rd_s), .slave_write(wr_s),
        .slave_writedata(wdata_s), .slave_byteenable(be_s),
        .slave_waitrequest(wreq_s), .slave_readdata(rdata_s),
        .slave_readdatavalid(rvalid_s), .slave_writeresponsevalid(wvalid_s),
        .slave_response(resp_s)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [18:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        e_rv;
        logic        e_wv;
        logic [1:0]  e_resp;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [32];

    function automatic vec_t mk(input logic r, input logic w, input logic [18:0] a,
                                input logic [31:0] d, input logic [3:0] b,
                                input logic erv, input logic ewv,
                                input logic [1:0] er, input logic [31:0] ed);
        vec_t v;
        v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.be = b;
        v.e_rv = erv; v.e_wv = ewv; v.e_resp = er; v.e_data = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic ok, input string detail);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [18:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        rd = r; wr = w; addr = a; wdata = d; be = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;

        // Write-response, streaming, byteenable, decode-error, boundary rows.
        // Each row's expectation is the response to the command two rows earlier.
        vecs[0]  = mk(0, 1, 19'd0,    32'd0,        4'hF, 0, 0, 2'b00, 32'd0);
        vecs[1]  = mk(0, 1, 19'd1,    32'd1,        4'hF, 0, 0, 2'b00, 32'd0);
        vecs[2]  = mk(0, 1, 19'd2,    32'd2,        4'hF, 0, 1, 2'b00, 32'd0);
        vecs[3]  = mk(0, 1, 19'd3,    32'd3,        4'hF, 0, 1, 2'b00, 32'd0);
        vecs[4]  = mk(0, 1, 19'd4,    32'd4,        4'hF, 0, 1, 2'b00, 32'd0);
        vecs[5]  = mk(0, 1, 19'd5,    32'd5,        4'hF, 0, 1, 2'b00, 32'd0);
        vecs[6]  = mk(0, 1, 19'd6,    32'd6,        4'hF, 0, 1, 2'b00, 32'd0);
        vecs[7]  = mk(0, 1, 19'd7,    32'd7,        4'hF, 0, 1, 2'b00, 32'd0);
        vecs[8]  = mk(1, 0, 19'd0,    32'd0,        4'h0, 0, 1, 2'b00, 32'd0);
        vecs[9]  = mk(1, 0, 19'd1,    32'd0,        4'h0, 0, 1, 2'b00, 32'd0);
        vecs[10] = mk(1, 0, 19'd2,    32'd0,        4'h0, 1, 0, 2'b00, 32'd0);
        vecs[11] = mk(1, 0, 19'd3,    32'd0,        4'h0, 1, 0, 2'b00, 32'd1);
        vecs[12] = mk(1, 0, 19'd4,    32'd0,        4'h0, 1, 0, 2'b00, 32'd2);
        vecs[13] = mk(1, 0, 19'd5,    32'd0,        4'h0, 1, 0, 2'b00, 32'd3);
        vecs[14] = mk(1, 0, 19'd6,    32'd0,        4'h0, 1, 0, 2'b00, 32'd4);
        vecs[15] = mk(1, 0, 19'd7,    32'd0,        4'h0, 1, 0, 2'b00, 32'd5);
        vecs[16] = mk(0, 1, 19'd5,    32'hA5A50001, 4'hF, 1, 0, 2'b00, 32'd6);
        vecs[17] = mk(1, 0, 19'd5,    32'd0,        4'h0, 1, 0, 2'b00, 32'd7);
        vecs[18] = mk(0, 1, 19'd9,    32'h11223344, 4'hF, 0, 1, 2'b00, 32'd0);
        vecs[19] = mk(0, 1, 19'd9,    32'h0000BB00, 4'h2, 1, 0, 2'b00, 32'hA5A50001);
        vecs[20] = mk(1, 0, 19'd9,    32'd0,        4'h0, 0, 1, 2'b00, 32'd0);
        vecs[21] = mk(1, 0, 19'd1024, 32'd0,        4'h0, 0, 1, 2'b00, 32'd0);
        vecs[22] = mk(0, 1, 19'd1024, 32'hDEADBEEF, 4'hF, 1, 0, 2'b00, 32'h1122BB44);
        vecs[23] = mk(1, 0, 19'd0,    32'd0,        4'h0, 1, 0, 2'b11, 32'd0);
        vecs[24] = mk(0, 1, 19'd3,    32'hFFFFFFFF, 4'h0, 0, 1, 2'b11, 32'd0);
        vecs[25] = mk(1, 1, 19'd3,    32'h12345678, 4'h1, 1, 0, 2'b00, 32'd0);
        vecs[26] = mk(1, 0, 19'd3,    32'd0,        4'h0, 0, 1, 2'b00, 32'd0);
        vecs[27] = mk(0, 1, 19'd1023, 32'hCAFEF00D, 4'hF, 0, 1, 2'b00, 32'd0);
        vecs[28] = mk(1, 0, 19'd1023, 32'd0,        4'h0, 1, 0, 2'b00, 32'h00000078);
        vecs[29] = mk(0, 0, 19'd0,    32'd0,        4'h0, 0, 1, 2'b00, 32'd0);
        vecs[30] = mk(0, 0, 19'd0,    32'd0,        4'h0, 1, 0, 2'b00, 32'hCAFEF00D);
        vecs[31] = mk(0, 0, 19'd0,    32'd0,        4'h0, 0, 0, 2'b00, 32'd0);

        rst = 1'b1; rst_s = 1'b1;
        drive(0, 0, '0, '0, '0);
        rd_s = 1'b0; wr_s = 1'b0; addr_s = '0; wdata_s = '0; be_s = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state",
              wreq === 1'b1 && rvalid === 1'b0 && wvalid === 1'b0 && resp === 2'b00 && rdata === 32'd0,
              $sformatf("wreq=%b rv=%b wv=%b resp=%b data=%h, required 1 0 0 00 00000000",
                        wreq, rvalid, wvalid, resp, rdata));
        check("reset_state_stall",
              wreq_s === 1'b1 && rvalid_s === 1'b0 && wvalid_s === 1'b0 && resp_s === 2'b00,
              $sformatf("wreq=%b rv=%b wv=%b resp=%b, required 1 0 0 00",
                        wreq_s, rvalid_s, wvalid_s, resp_s));

        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            @(negedge clk);
            ok = (wreq === 1'b0) && (rvalid === vecs[i].e_rv) && (wvalid === vecs[i].e_wv) &&
                 (resp === vecs[i].e_resp) && (!vecs[i].e_rv || rdata === vecs[i].e_data);
            check($sformatf("row%0d", i), ok,
                  $sformatf("wreq=%b rv=%b wv=%b resp=%b data=%h, required 0 %b %b %b %h",
                            wreq, rvalid, wvalid, resp, rdata,
                            vecs[i].e_rv, vecs[i].e_wv, vecs[i].e_resp, vecs[i].e_data));
            next_cycle();
        end

        // Reset flush: two reads accepted, reset asserted right after the second
        drive(1, 0, 19'd1, '0, '0);
        next_cycle();
        drive(1, 0, 19'd2, '0, '0);
        next_cycle();
        rst = 1'b1;
        drive(0, 0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("flush_rst%0d", i),
                  wreq === 1'b1 && rvalid === 1'b0 && wvalid === 1'b0,
                  $sformatf("wreq=%b rv=%b wv=%b, required 1 0 0", wreq, rvalid, wvalid));
            next_cycle();
        end
        rst = 1'b0;
        drive(1, 0, 19'd2, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) begin
                check($sformatf("flush_post%0d", i),
                      wreq === 1'b0 && rvalid === 1'b0 && wvalid === 1'b0,
                      $sformatf("wreq=%b rv=%b wv=%b, required 0 0 0", wreq, rvalid, wvalid));
            end else begin
                check("flush_read",
                      rvalid === 1'b1 && rdata === 32'd2 && resp === 2'b00,
                      $sformatf("rv=%b data=%h resp=%b, required 1 00000002 00", rvalid, rdata, resp));
            end
            next_cycle();
            drive(0, 0, '0, '0, '0);
        end

        // Injected stalls: waitrequest high in cycles 16..18, 35..37
        rst_s = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            logic        e_wq, e_rv, e_wv;
            logic [31:0] e_d;
            rd_s = 1'b0; wr_s = 1'b0; addr_s = '0; wdata_s = '0; be_s = 4'hF;
            case (n)
                0: begin wr_s = 1'b1; addr_s = 19'd1; wdata_s = 32'h0000AAAA; end
                1: begin wr_s = 1'b1; addr_s = 19'd2; wdata_s = 32'h0000BBBB; end
                2: begin wr_s = 1'b1; addr_s = 19'd3; wdata_s = 32'h0000CCCC; end
                14: begin rd_s = 1'b1; addr_s = 19'd1; end
                15: begin rd_s = 1'b1; addr_s = 19'd2; end
                16, 17, 18, 19: begin rd_s = 1'b1; addr_s = 19'd3; end
                default: ;
            endcase
            e_wq = ((n % 19) >= 16);
            e_wv = (n >= 2 && n <= 4);
            e_rv = (n == 16 || n == 17 || n == 21);
            e_d  = (n == 16) ? 32'h0000AAAA : (n == 17) ? 32'h0000BBBB : 32'h0000CCCC;
            @(negedge clk);
            check($sformatf("stall_c%0d", n),
                  wreq_s === e_wq && rvalid_s === e_rv && wvalid_s === e_wv &&
                  resp_s === 2'b00 && (!e_rv || rdata_s === e_d),
                  $sformatf("wreq=%b rv=%b wv=%b resp=%b data=%h, required %b %b %b 00 %h",
                            wreq_s, rvalid_s, wvalid_s, resp_s, rdata_s, e_wq, e_rv, e_wv, e_d));
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
